mul_seq_unit: RTL and testbench

- Iterative radix-2 shift-add multiplier in the Execute stage. It consumes the 4-bit ALU control code produced by the ALU decoder.
- When the code is MUL (4'b1010), it captures SrcA/SrcB, stalls the pipeline while it iterates, then presents the low WIDTH bits of the product (RV32M MUL semantics) for one cycle.
- All other ALU codes pass through with no effect: no stall, no state change.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/mul_seq_unit_if.sv | 25 ++
 rtl/mul_seq_unit.sv | 119 +++++++++++
 tb/tb_mul_seq_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: decoder control codes and the multiplier FSM state type.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_seq_unit_if.sv
// Execute-stage multiplier bus: operands and op code in, stall/done/result out.
interface mul_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             flush;
    logic             MulStall;
    logic             MulDone;
    logic [WIDTH-1:0] MulResult;
    logic             Busy;

    // Pipeline side: drives the operation, observes stall and result.
    modport master (
        output ALUControl, SrcA, SrcB, flush,
        input  MulStall, MulDone, MulResult, Busy
    );

    // Multiplier side.
    modport slave (
        input  ALUControl, SrcA, SrcB, flush,
        output MulStall, MulDone, MulResult, Busy
    );
endinterface

// File: rtl/mul_seq_unit.sv
// Iterative radix-2 shift-add multiplier for the Execute stage.
// Keeps the low WIDTH bits of the product (RV32M MUL); stalls the pipe while iterating.
//
// state | meaning
// IDLE  | waiting; a MUL code without flush stalls and starts this cycle
// RUN   | one multiplier bit consumed per cycle, pipeline held
// DONE  | result valid for one cycle, pipeline released
module mul_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input logic          clk,
    input logic          rst,
    mul_seq_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    mul_state_t       state;
    mul_state_t       state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] result;

    logic             is_mul;
    logic [WIDTH-1:0] acc_add;
    logic [WIDTH-1:0] mplier_shr;
    logic             last_step;

    assign is_mul     = (bus.ALUControl == ALU_MUL) && !bus.flush;
    assign acc_add    = mplier[0] ? (acc + mcand) : acc;
    assign mplier_shr = mplier >> 1;
    assign last_step  = (count == CW'(1)) || (EARLY_EXIT && (mplier_shr == '0));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; rst gates outputs so they drop at once.
    always_comb begin
        state_nxt    = state;
        bus.MulStall = 1'b0;
        bus.MulDone  = 1'b0;
        bus.Busy     = 1'b0;
        unique case (state)
            IDLE: begin
                bus.MulStall = is_mul && !rst;
                if (is_mul) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                bus.MulStall = !rst;
                bus.Busy     = !rst;
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // The MUL still on ALUControl here is the one just finished.
                bus.MulDone = !bus.flush && !rst;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, shift-add iteration and result latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (is_mul) begin
                        acc    <= '0;
                        mcand  <= bus.SrcA;
                        mplier <= bus.SrcB;
                        count  <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    // A flushed operation leaves the previous result visible.
                    if (!bus.flush) begin
                        acc    <= acc_add;
                        mcand  <= mcand << 1;
                        mplier <= mplier_shr;
                        count  <= count - CW'(1);
                        if (last_step) begin
                            result <= acc_add;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.MulResult = result;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed bench for mul_seq_unit: one instance with full iteration, one with early exit.
module tb_mul_seq_unit;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst;

    logic [3:0]   alu;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         flush;

    int checks   = 0;
    int failures = 0;

    mul_seq_unit_if #(.WIDTH(W)) bus   ();
    mul_seq_unit_if #(.WIDTH(W)) bus_e ();

    assign bus.ALUControl   = alu;
    assign bus.SrcA         = src_a;
    assign bus.SrcB         = src_b;
    assign bus.flush        = flush;
    assign bus_e.ALUControl = alu;
    assign bus_e.SrcA       = src_a;
    assign bus_e.SrcB       = src_b;
    assign bus_e.flush      = flush;

    mul_seq_unit #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    mul_seq_unit #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_e (
        .clk (clk),
        .rst (rst),
        .bus (bus_e.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Holds a MUL on the bus until MulDone (bounded), returns result and cycle of MulDone.
    task automatic run_mul(input bit ee, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int lat);
        int i;
        lat = -1;
        res = '0;
        i   = 0;
        while (lat < 0 && i < 100) begin
            @(negedge clk);
            alu   = ALU_MUL;
            src_a = a;
            src_b = b;
            #1;
            if (ee ? bus_e.MulDone : bus.MulDone) begin
                res = ee ? bus_e.MulResult : bus.MulResult;
                lat = i;
            end
            i++;
        end
        @(negedge clk);
        alu = ALU_ADD;
    endtask

    logic [31:0] res;
    int          lat;
    int          done_cnt;
    int          done_c1;
    int          done_c2;
    logic [31:0] done_v1;
    logic [31:0] done_v2;

    initial begin
        rst   = 1'b1;
        alu   = ALU_MUL;
        src_a = 32'd7;
        src_b = 32'd6;
        flush = 1'b0;
        #1;
        chk("rst_stall",  32'(bus.MulStall), 32'd0);
        chk("rst_busy",   32'(bus.Busy),     32'd0);
        chk("rst_done",   32'(bus.MulDone),  32'd0);
        chk("rst_result", bus.MulResult,     32'd0);
        alu = ALU_ADD;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 7 x 6: stall 0..32, busy 1..32, done only at 33 with 42.
        for (int c = 0; c <= 35; c++) begin
            @(negedge clk);
            alu   = (c <= 33) ? ALU_MUL : ALU_ADD;
            src_a = 32'd7;
            src_b = 32'd6;
            #1;
            chk($sformatf("m76_stall_c%0d", c), 32'(bus.MulStall), 32'(c <= 32));
            chk($sformatf("m76_busy_c%0d", c),  32'(bus.Busy),     32'(c >= 1 && c <= 32));
            chk($sformatf("m76_done_c%0d", c),  32'(bus.MulDone),  32'(c == 33));
            if (c == 33) chk("m76_result", bus.MulResult, 32'd42);
        end

        // Flush in RUN cycle 10: back to IDLE, no done, previous 42 kept.
        done_cnt = 0;
        for (int c = 0; c <= 45; c++) begin
            @(negedge clk);
            alu   = (c < 10) ? ALU_MUL : ALU_ADD;
            src_a = 32'd7;
            src_b = 32'd6;
            flush = (c == 10);
            #1;
            if (bus.MulDone) done_cnt++;
            if (c == 11) begin
                chk("flush_busy_after",  32'(bus.Busy),     32'd0);
                chk("flush_stall_after", 32'(bus.MulStall), 32'd0);
            end
        end
        flush = 1'b0;
        chk("flush_no_done",     32'(done_cnt),  32'd0);
        chk("flush_result_kept", bus.MulResult,  32'd42);

        // Non-MUL codes have no effect.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            alu   = ALU_ADD;
            src_a = 32'(c * 3 + 1);
            src_b = 32'(c + 5);
            #1;
            chk($sformatf("add_stall_c%0d", c), 32'(bus.MulStall), 32'd0);
            chk($sformatf("add_busy_c%0d", c),  32'(bus.Busy),     32'd0);
            chk($sformatf("add_done_c%0d", c),  32'(bus.MulDone),  32'd0);
        end

        // Async reset in RUN cycle 5: outputs drop without a clock edge.
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            alu   = ALU_MUL;
            src_a = 32'd7;
            src_b = 32'd6;
            #1;
        end
        chk("prerst_busy", 32'(bus.Busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_stall",  32'(bus.MulStall), 32'd0);
        chk("midrst_busy",   32'(bus.Busy),     32'd0);
        chk("midrst_done",   32'(bus.MulDone),  32'd0);
        chk("midrst_result", bus.MulResult,     32'd0);
        @(negedge clk);
        alu = ALU_ADD;
        rst = 1'b0;

        run_mul(1'b0, 32'd2, 32'd3, res, lat);
        chk("m23_result", res, 32'd6);
        chk("m23_lat",    32'(lat), 32'd33);

        run_mul(1'b0, 32'hFFFF_FFFF, 32'd2, res, lat);
        chk("mffx2_result", res, 32'hFFFF_FFFE);

        run_mul(1'b0, 32'h8000_0000, 32'h8000_0000, res, lat);
        chk("m80x80_result", res, 32'h0000_0000);

        // Back-to-back: 3x5 then 0x10000 x 0x10000 held through the first DONE.
        done_cnt = 0;
        done_c1  = -1;
        done_c2  = -1;
        done_v1  = '1;
        done_v2  = '1;
        for (int c = 0; c <= 80; c++) begin
            @(negedge clk);
            alu   = (c <= 67) ? ALU_MUL : ALU_ADD;
            src_a = (c < 33) ? 32'd3 : 32'h0001_0000;
            src_b = (c < 33) ? 32'd5 : 32'h0001_0000;
            #1;
            if (c == 34) chk("b2b_second_start_stall", 32'(bus.MulStall), 32'd1);
            if (bus.MulDone) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_c1 = c;
                    done_v1 = bus.MulResult;
                end else begin
                    done_c2 = c;
                    done_v2 = bus.MulResult;
                end
            end
        end
        chk("b2b_done_count", 32'(done_cnt), 32'd2);
        chk("b2b_first_cyc",  32'(done_c1),  32'd33);
        chk("b2b_first_val",  done_v1,       32'd15);
        chk("b2b_gap",        32'(done_c2 - done_c1), 32'd34);
        chk("b2b_second_val", done_v2,       32'd0);

        // Early-exit instance.
        @(negedge clk);
        @(negedge clk);
        run_mul(1'b1, 32'd12345, 32'd1, res, lat);
        chk("ee_b1_result", res, 32'd12345);
        chk("ee_b1_lat",    32'(lat), 32'd2);

        run_mul(1'b1, 32'd12345, 32'd0, res, lat);
        chk("ee_b0_result", res, 32'd0);
        chk("ee_b0_lat",    32'(lat), 32'd2);

        run_mul(1'b1, 32'd9, 32'd11, res, lat);
        chk("ee_9x11_result", res, 32'd99);
        chk("ee_9x11_lat",    32'(lat), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
